// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time target generator.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHOW,
        DONE
    } state_t;

    localparam int PATTERN_W       = 8;
    localparam int LFSR_W          = 16;
    localparam int MATCH_GUARD_CYC = 2;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_target_gen_if.sv
// Start/compare/score signal bundle between the button logic, compare block
// and score display. The generator uses the master view.
interface reaction_target_gen_if;
    import reaction_pkg::*;

    logic                 start;
    logic                 Match;
    logic [PATTERN_W-1:0] LED2;
    logic [15:0]          react_ms;
    logic                 done;
    logic                 timeout;
    logic                 busy;

    modport master (
        input  start, Match,
        output LED2, react_ms, done, timeout, busy
    );

    modport slave (
        output start, Match,
        input  LED2, react_ms, done, timeout, busy
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: one-cycle pulse every TICK_DIV clocks,
// synchronous restart puts the phase back to the start of a period.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign o_tick = w_wrap;

    // Divider counter: wraps at TICK_DIV-1, restart forces zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reaction_target_gen.sv
// Reaction-time target generator: waits a pseudo-random delay, shows an LED
// pattern, then measures milliseconds until the compare block reports Match.
// Optional build macro REACTION_ONEHOT_PATTERN_EN: show a single lit LED.
module reaction_target_gen
    import reaction_pkg::*;
#(
    parameter int          TICK_DIV        = 50000,
    parameter int          MIN_DELAY_MS    = 1000,
    parameter int          DELAY_RAND_BITS = 10,
    parameter int          TIMEOUT_MS      = 9999,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                  clk50M,
    input  logic                  rst,
    reaction_target_gen_if.master io
);

    state_t               r_state, w_state_nxt;
    logic [LFSR_W-1:0]    r_lfsr;
    logic                 r_start_q;
    logic                 w_start_rise;
    logic [15:0]          r_ms, w_ms_nxt;
    logic [15:0]          r_delay, w_delay_nxt;
    logic [15:0]          r_react, w_react_nxt;
    logic [1:0]           r_guard, w_guard_nxt;
    logic [PATTERN_W-1:0] r_led, w_led_nxt, w_pattern;
    logic                 r_done, w_done_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 w_tick, w_restart;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk50M),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    assign w_start_rise = io.start & ~r_start_q;

`ifdef REACTION_ONEHOT_PATTERN_EN
    assign w_pattern = PATTERN_W'(1) << r_lfsr[10:8];
`else
    assign w_pattern = (r_lfsr[15:8] == '0) ? PATTERN_W'(1) : r_lfsr[15:8];
`endif

    // Free-running LFSR and start edge history, independent of state
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_lfsr    <= LFSR_SEED;
            r_start_q <= 1'b0;
        end else begin
            r_lfsr    <= lfsr_next(r_lfsr);
            r_start_q <= io.start;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ms      <= '0;
            r_delay   <= '0;
            r_react   <= '0;
            r_guard   <= '0;
            r_led     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ms      <= w_ms_nxt;
            r_delay   <= w_delay_nxt;
            r_react   <= w_react_nxt;
            r_guard   <= w_guard_nxt;
            r_led     <= w_led_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_ms_nxt      = r_ms;
        w_delay_nxt   = r_delay;
        w_react_nxt   = r_react;
        w_guard_nxt   = r_guard;
        w_led_nxt     = r_led;
        w_done_nxt    = r_done;
        w_timeout_nxt = r_timeout;
        w_restart     = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (w_start_rise) begin
                    w_state_nxt   = DELAY;
                    w_delay_nxt   = 16'(MIN_DELAY_MS) + 16'(r_lfsr[DELAY_RAND_BITS-1:0]);
                    w_ms_nxt      = '0;
                    w_react_nxt   = '0;
                    w_led_nxt     = '0;
                    w_done_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_restart     = 1'b1;
                end
            end
            DELAY: begin
                if (w_tick) begin
                    if (r_ms + 16'd1 >= r_delay) begin
                        w_state_nxt = SHOW;
                        w_led_nxt   = w_pattern;
                        w_react_nxt = '0;
                        w_guard_nxt = '0;
                        w_restart   = 1'b1;
                    end else begin
                        w_ms_nxt = r_ms + 16'd1;
                    end
                end
            end
            SHOW: begin
                // Match beats a same-cycle tick, so the count is not bumped
                if (io.Match && (r_guard == 2'(MATCH_GUARD_CYC))) begin
                    w_state_nxt = DONE;
                    w_led_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    if (r_guard != 2'(MATCH_GUARD_CYC)) begin
                        w_guard_nxt = r_guard + 2'd1;
                    end
                    if (w_tick) begin
                        if (r_react + 16'd1 >= 16'(TIMEOUT_MS)) begin
                            w_state_nxt   = DONE;
                            w_led_nxt     = '0;
                            w_done_nxt    = 1'b1;
                            w_timeout_nxt = 1'b1;
                            w_react_nxt   = 16'(TIMEOUT_MS);
                        end else begin
                            w_react_nxt = r_react + 16'd1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == DELAY) || (w_state_nxt == SHOW);
    end

    assign io.LED2     = r_led;
    assign io.react_ms = r_react;
    assign io.done     = r_done;
    assign io.timeout  = r_timeout;
    assign io.busy     = r_busy;

endmodule
